// File: rtl/cvp_pkg.sv
// Shared types and register map for the CVP power-controller register file.
package cvp_pkg;

    typedef enum logic [1:0] {
        PWR_OFF     = 2'd0,
        PWR_RAMP    = 2'd1,
        PWR_ON      = 2'd2,
        PWR_ISOLATE = 2'd3
    } pwr_state_t;

    typedef enum logic [1:0] {
        BUS_IDLE = 2'd0,
        BUS_WAIT = 2'd1,
        BUS_RESP = 2'd2
    } bus_state_t;

    localparam int unsigned DATA_W     = 64;
    localparam int unsigned BE_W       = 8;
    localparam int unsigned WADDR_W    = 29;
    localparam int unsigned FREQ_W     = 3;
    localparam int unsigned STATUS_W   = 5;
    localparam int unsigned WAIT_W     = 4;

    localparam int unsigned CTRL_IDX   = 0;
    localparam int unsigned STATUS_IDX = 1;
    localparam int unsigned PWR_EN_BIT = 0;
    localparam int unsigned FREQ_LSB   = 8;
    localparam int unsigned FREQ_MSB   = 10;

    // Request fields latched in IDLE and held until the response.
    typedef struct packed {
        logic [WADDR_W-1:0] addr;
        logic [DATA_W-1:0]  data;
        logic [BE_W-1:0]    be;
        logic               wr;
    } cvp_req_t;

endpackage

// File: rtl/cvp_pwr_fsm.sv
// Core-domain power sequencer: OFF -> RAMP -> ON -> ISOLATE -> OFF with dwell counters.
module cvp_pwr_fsm
    import cvp_pkg::*;
#(
    parameter int unsigned RAMP_CYCLES = 16,
    parameter int unsigned ISO_CYCLES  = 8
) (
    input  logic       clk_cvp,
    input  logic       rst_async,
    input  logic       pwr_en,
    output pwr_state_t state,
    output logic       core_power_on,
    output logic       core_rst_n,
    output logic       busy
);

    localparam int unsigned MAX_CYC = (RAMP_CYCLES > ISO_CYCLES) ? RAMP_CYCLES : ISO_CYCLES;
    localparam int unsigned CNT_W   = $clog2(MAX_CYC + 1);

    pwr_state_t       state_next;
    logic [CNT_W-1:0] cnt, cnt_next;
    logic             power_on_next, rst_n_next, busy_next;

    always_ff @(posedge clk_cvp or posedge rst_async) begin
        if (rst_async) begin
            state         <= PWR_OFF;
            cnt           <= '0;
            core_power_on <= 1'b0;
            core_rst_n    <= 1'b0;
            busy          <= 1'b0;
        end else begin
            state         <= state_next;
            cnt           <= cnt_next;
            core_power_on <= power_on_next;
            core_rst_n    <= rst_n_next;
            busy          <= busy_next;
        end
    end

    // Outputs are decoded from the next state so they register with it.
    always_comb begin
        state_next = state;
        cnt_next   = '0;
        case (state)
            PWR_OFF: begin
                if (pwr_en) state_next = PWR_RAMP;
            end
            PWR_RAMP: begin
                if (!pwr_en)
                    state_next = PWR_ISOLATE;
                else if (cnt == CNT_W'(RAMP_CYCLES - 1))
                    state_next = PWR_ON;
                else
                    cnt_next = cnt + CNT_W'(1);
            end
            PWR_ON: begin
                if (!pwr_en) state_next = PWR_ISOLATE;
            end
            PWR_ISOLATE: begin
                if (cnt == CNT_W'(ISO_CYCLES - 1))
                    state_next = PWR_OFF;
                else
                    cnt_next = cnt + CNT_W'(1);
            end
        endcase
        power_on_next = (state_next != PWR_OFF);
        rst_n_next    = (state_next == PWR_ON);
        busy_next     = (state_next == PWR_RAMP) || (state_next == PWR_ISOLATE);
    end

endmodule

// File: rtl/cvp_regfile.sv
// CVP bus slave: CTRL/STATUS registers, byte-enabled scratch words, wait states and power sequencer.
module cvp_regfile
    import cvp_pkg::*;
#(
    parameter int unsigned NUM_WORDS      = 16,
    parameter int unsigned WAIT_STATES    = 0,
    parameter int unsigned RAMP_CYCLES    = 16,
    parameter int unsigned ISO_CYCLES     = 8,
    parameter int unsigned NUM_FREQ_MODES = 4
) (
    input  logic              clk_cvp,
    input  logic              rst_async,
    input  logic              pwr_req,
    input  logic [63:0]       pwr_w_data,
    input  logic [31:3]       pwr_addr,
    input  logic [7:0]        pwr_be,
    input  logic              pwr_wr_rd,
    output logic              pwr_ack,
    output logic [63:0]       pwr_r_data,
    output logic              pwr_error,
    output logic              core_power_on,
    output logic              core_rst_n,
    output logic [2:0]        freq_mode,
    output logic              busy
);

    localparam int unsigned IDX_W     = $clog2(NUM_WORDS);
    localparam int unsigned WAIT_LAST = (WAIT_STATES == 0) ? 0 : WAIT_STATES - 1;

    bus_state_t          bus_state, bus_next;
    cvp_req_t            req_q;
    logic [STATUS_W-1:0] status_q;
    logic [WAIT_W-1:0]   wait_cnt, wait_next;
    logic [DATA_W-1:0]   mem [NUM_WORDS];
    logic                ctrl_pwr_en;
    logic [FREQ_W-1:0]   ctrl_freq;
    pwr_state_t          pwr_state;

    logic                capture, in_resp, ack_next, error_next;
    logic [DATA_W-1:0]   r_data_next, rd_word;
    logic [IDX_W-1:0]    idx;
    logic                out_of_range, is_ctrl, is_status, freq_bad, req_err;
    logic [FREQ_W-1:0]   new_freq;

    cvp_pwr_fsm #(
        .RAMP_CYCLES (RAMP_CYCLES),
        .ISO_CYCLES  (ISO_CYCLES)
    ) u_pwr_fsm (
        .clk_cvp       (clk_cvp),
        .rst_async     (rst_async),
        .pwr_en        (ctrl_pwr_en),
        .state         (pwr_state),
        .core_power_on (core_power_on),
        .core_rst_n    (core_rst_n),
        .busy          (busy)
    );

    assign freq_mode = ctrl_freq;

    // Address decode and error classification of the captured request.
    always_comb begin
        idx          = req_q.addr[IDX_W-1:0];
        out_of_range = (req_q.addr >= WADDR_W'(NUM_WORDS));
        is_ctrl      = !out_of_range && (idx == IDX_W'(CTRL_IDX));
        is_status    = !out_of_range && (idx == IDX_W'(STATUS_IDX));
        new_freq     = req_q.data[FREQ_MSB:FREQ_LSB];
        freq_bad     = req_q.be[1] && ({1'b0, new_freq} >= (FREQ_W + 1)'(NUM_FREQ_MODES));
        req_err      = out_of_range
                     || (req_q.wr && is_status)
                     || (req_q.wr && is_ctrl && freq_bad);
        rd_word      = '0;
        if (out_of_range) begin
            rd_word = '0;
        end else if (is_ctrl) begin
            rd_word[PWR_EN_BIT]        = ctrl_pwr_en;
            rd_word[FREQ_MSB:FREQ_LSB] = ctrl_freq;
        end else if (is_status) begin
            rd_word[STATUS_W-1:0] = status_q;
        end else begin
            rd_word = mem[idx];
        end
    end

    // Bus sequencing: IDLE captures, WAIT pads, RESP produces the registered ack.
    always_comb begin
        bus_next    = bus_state;
        wait_next   = wait_cnt;
        capture     = 1'b0;
        in_resp     = 1'b0;
        ack_next    = 1'b0;
        error_next  = 1'b0;
        r_data_next = '0;
        case (bus_state)
            BUS_IDLE: begin
                if (pwr_req) begin
                    capture   = 1'b1;
                    wait_next = '0;
                    bus_next  = (WAIT_STATES == 0) ? BUS_RESP : BUS_WAIT;
                end
            end
            BUS_WAIT: begin
                if (wait_cnt == WAIT_W'(WAIT_LAST))
                    bus_next = BUS_RESP;
                else
                    wait_next = wait_cnt + WAIT_W'(1);
            end
            BUS_RESP: begin
                in_resp     = 1'b1;
                ack_next    = 1'b1;
                error_next  = req_err;
                r_data_next = req_q.wr ? '0 : rd_word;
                bus_next    = BUS_IDLE;
            end
            default: bus_next = BUS_IDLE;
        endcase
    end

    always_ff @(posedge clk_cvp or posedge rst_async) begin
        if (rst_async) begin
            bus_state  <= BUS_IDLE;
            wait_cnt   <= '0;
            req_q      <= '0;
            status_q   <= '0;
            pwr_ack    <= 1'b0;
            pwr_r_data <= '0;
            pwr_error  <= 1'b0;
        end else begin
            bus_state  <= bus_next;
            wait_cnt   <= wait_next;
            pwr_ack    <= ack_next;
            pwr_r_data <= r_data_next;
            pwr_error  <= error_next;
            if (capture) begin
                req_q    <= '{addr: pwr_addr, data: pwr_w_data, be: pwr_be, wr: pwr_wr_rd};
                status_q <= {busy, pwr_state, core_rst_n, core_power_on};
            end
        end
    end

    // CTRL commit; a rejected FREQ leaves the field but still lets PWR_EN through.
    always_ff @(posedge clk_cvp or posedge rst_async) begin
        if (rst_async) begin
            ctrl_pwr_en <= 1'b0;
            ctrl_freq   <= '0;
        end else if (in_resp && req_q.wr && is_ctrl) begin
            if (req_q.be[0]) ctrl_pwr_en <= req_q.data[PWR_EN_BIT];
            if (req_q.be[1] && !freq_bad) ctrl_freq <= new_freq;
        end
    end

    always_ff @(posedge clk_cvp or posedge rst_async) begin
        if (rst_async) begin
            for (int i = 0; i < int'(NUM_WORDS); i++) mem[i] <= '0;
        end else if (in_resp && req_q.wr && !out_of_range && !is_ctrl && !is_status) begin
            for (int b = 0; b < int'(BE_W); b++)
                if (req_q.be[b]) mem[idx][8*b +: 8] <= req_q.data[8*b +: 8];
        end
    end

endmodule

// File: tb/tb_cvp_regfile.sv
// Directed bench for cvp_regfile: one instance with no wait states, one with three.
module tb_cvp_regfile;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_a = 1'b0, req_b = 1'b0;
    logic        wr = 1'b0;
    logic [31:3] addr = '0;
    logic [63:0] wdata = '0;
    logic [7:0]  be = '0;

    logic        ack_a, err_a, pon_a, rstn_a, busy_a;
    logic [63:0] rdata_a;
    logic [2:0]  freq_a;
    logic        ack_b, err_b, pon_b, rstn_b, busy_b;
    logic [63:0] rdata_b;
    logic [2:0]  freq_b;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    cvp_regfile #(.WAIT_STATES(0)) dut_a (
        .clk_cvp(clk), .rst_async(rst), .pwr_req(req_a), .pwr_w_data(wdata),
        .pwr_addr(addr), .pwr_be(be), .pwr_wr_rd(wr), .pwr_ack(ack_a),
        .pwr_r_data(rdata_a), .pwr_error(err_a), .core_power_on(pon_a),
        .core_rst_n(rstn_a), .freq_mode(freq_a), .busy(busy_a)
    );

    cvp_regfile #(.WAIT_STATES(3)) dut_b (
        .clk_cvp(clk), .rst_async(rst), .pwr_req(req_b), .pwr_w_data(wdata),
        .pwr_addr(addr), .pwr_be(be), .pwr_wr_rd(wr), .pwr_ack(ack_b),
        .pwr_r_data(rdata_b), .pwr_error(err_b), .core_power_on(pon_b),
        .core_rst_n(rstn_b), .freq_mode(freq_b), .busy(busy_b)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // One bus transfer; lat = clock edges from request sampling to the ack.
    task automatic xfer(input bit sel_b, input logic w, input logic [28:0] a,
                        input logic [63:0] d, input logic [7:0] e,
                        output logic [63:0] rd, output logic er, output int lat);
        wr = w; addr = a; wdata = d; be = e;
        if (sel_b) req_b = 1'b1; else req_a = 1'b1;
        lat = -1; rd = '0; er = 1'b0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (sel_b ? ack_b : ack_a) begin
                lat = i;
                rd  = sel_b ? rdata_b : rdata_a;
                er  = sel_b ? err_b : err_a;
                break;
            end
        end
        req_a = 1'b0; req_b = 1'b0;
        if (lat < 0) begin
            n_vec++; n_err++;
            $display("FAIL xfer_timeout: no ack for addr %h", a);
        end
    endtask

    logic [63:0] rd;
    logic        er;
    int          lat, bad, acks, gap;

    initial begin
        repeat (3) @(negedge clk);
        chk("rst_ack",   64'(ack_a),   64'd0);
        chk("rst_rdata", rdata_a,      64'd0);
        chk("rst_err",   64'(err_a),   64'd0);
        chk("rst_pon",   64'(pon_a),   64'd0);
        chk("rst_rstn",  64'(rstn_a),  64'd0);
        chk("rst_freq",  64'(freq_a),  64'd0);
        chk("rst_busy",  64'(busy_a),  64'd0);
        rst = 1'b0;
        @(negedge clk);

        // Scratch after reset, then byte-enabled merges.
        xfer(0, 0, 29'd5, 64'd0, 8'hFF, rd, er, lat);
        chk("scratch_rst", rd, 64'd0);
        xfer(0, 1, 29'd5, 64'h1122334455667788, 8'h0F, rd, er, lat);
        chk("wr5_rdata", rd, 64'd0);
        chk("wr5_err", 64'(er), 64'd0);
        chk("wr5_lat", 64'(lat), 64'd1);
        xfer(0, 0, 29'd5, 64'd0, 8'h00, rd, er, lat);
        chk("rd5_data", rd, 64'h0000000055667788);
        chk("rd5_err", 64'(er), 64'd0);
        chk("rd5_lat", 64'(lat), 64'd1);
        xfer(0, 1, 29'd5, 64'hAABBCCDD00000000, 8'hF0, rd, er, lat);
        xfer(0, 0, 29'd5, 64'd0, 8'h00, rd, er, lat);
        chk("rd5_merge", rd, 64'hAABBCCDD55667788);
        xfer(0, 1, 29'd15, 64'hDEADBEEFCAFEF00D, 8'hFF, rd, er, lat);
        xfer(0, 0, 29'd15, 64'd0, 8'h00, rd, er, lat);
        chk("rd15_top", rd, 64'hDEADBEEFCAFEF00D);

        // Wait-state latency and back-to-back with req held.
        xfer(1, 0, 29'd2, 64'd0, 8'h00, rd, er, lat);
        chk("ws3_lat", 64'(lat), 64'd4);
        wr = 1'b0; addr = 29'd2; req_b = 1'b1;
        acks = 0; gap = -1;
        for (int i = 0; i < 30 && acks < 2; i++) begin
            @(negedge clk);
            if (ack_b) begin
                acks++;
                if (acks == 1) gap = 0;
            end else if (acks == 1) begin
                gap++;
            end
        end
        req_b = 1'b0;
        chk("ws3_held_acks", 64'(acks), 64'd2);
        chk("ws3_held_gap", 64'(gap + 1), 64'd5);
        @(negedge clk);

        // Range and STATUS write errors.
        xfer(0, 0, 29'd16, 64'd0, 8'h00, rd, er, lat);
        chk("oor_rd_data", rd, 64'd0);
        chk("oor_rd_err", 64'(er), 64'd1);
        xfer(0, 1, 29'd16, 64'h0000000000000301, 8'hFF, rd, er, lat);
        chk("oor_wr_err", 64'(er), 64'd1);
        xfer(0, 0, 29'd0, 64'd0, 8'h00, rd, er, lat);
        chk("oor_no_alias", rd, 64'd0);
        xfer(0, 1, 29'd1, 64'hFFFFFFFFFFFFFFFF, 8'hFF, rd, er, lat);
        chk("wr_status_err", 64'(er), 64'd1);
        chk("wr_status_rdata", rd, 64'd0);
        xfer(0, 0, 29'd1, 64'd0, 8'h00, rd, er, lat);
        chk("status_off", rd, 64'd0);
        chk("status_off_err", 64'(er), 64'd0);

        // Power-up: RAMP for 16 cycles, then ON.
        xfer(0, 1, 29'd0, 64'h1, 8'h01, rd, er, lat);
        chk("pon_r1", 64'(pon_a), 64'd0);
        @(negedge clk);
        chk("pon_r2", 64'(pon_a), 64'd1);
        chk("ramp_rstn", 64'(rstn_a), 64'd0);
        chk("ramp_busy", 64'(busy_a), 64'd1);
        bad = 0;
        for (int i = 1; i < 16; i++) begin
            @(negedge clk);
            if (rstn_a || !busy_a || !pon_a) bad++;
        end
        chk("ramp_hold", 64'(bad), 64'd0);
        @(negedge clk);
        chk("on_rstn", 64'(rstn_a), 64'd1);
        chk("on_busy", 64'(busy_a), 64'd0);
        xfer(0, 0, 29'd1, 64'd0, 8'h00, rd, er, lat);
        chk("status_on", rd, 64'h0B);

        // Power-down: rst_n drops at once, supply after 8 cycles of ISOLATE.
        xfer(0, 1, 29'd0, 64'h0, 8'h01, rd, er, lat);
        @(negedge clk);
        chk("iso_rstn", 64'(rstn_a), 64'd0);
        chk("iso_pon", 64'(pon_a), 64'd1);
        chk("iso_busy", 64'(busy_a), 64'd1);
        bad = 0;
        for (int i = 1; i < 8; i++) begin
            @(negedge clk);
            if (!pon_a || rstn_a || !busy_a) bad++;
        end
        chk("iso_hold", 64'(bad), 64'd0);
        @(negedge clk);
        chk("off_pon", 64'(pon_a), 64'd0);
        chk("off_busy", 64'(busy_a), 64'd0);

        // FREQ legality.
        xfer(0, 1, 29'd0, 64'h500, 8'h02, rd, er, lat);
        chk("freq5_err", 64'(er), 64'd1);
        chk("freq5_mode", 64'(freq_a), 64'd0);
        xfer(0, 1, 29'd0, 64'h300, 8'h02, rd, er, lat);
        chk("freq3_err", 64'(er), 64'd0);
        chk("freq3_mode", 64'(freq_a), 64'd3);
        xfer(0, 1, 29'd0, 64'h601, 8'h03, rd, er, lat);
        chk("freq6_en_err", 64'(er), 64'd1);
        xfer(0, 0, 29'd0, 64'd0, 8'h00, rd, er, lat);
        chk("ctrl_rd", rd, 64'h301);

        // Reset during RAMP (PWR_EN was just set above).
        @(negedge clk);
        @(negedge clk);
        chk("pre_rst_pon", 64'(pon_a), 64'd1);
        rst = 1'b1;
        #1;
        chk("mid_rst_pon", 64'(pon_a), 64'd0);
        chk("mid_rst_rstn", 64'(rstn_a), 64'd0);
        chk("mid_rst_busy", 64'(busy_a), 64'd0);
        chk("mid_rst_freq", 64'(freq_a), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        xfer(0, 0, 29'd1, 64'd0, 8'h00, rd, er, lat);
        chk("status_after_rst", rd, 64'd0);

        // Reset during WAIT drops the pending ack.
        wr = 1'b0; addr = 29'd2; req_b = 1'b1;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        req_b = 1'b0;
        #1;
        chk("wait_rst_ack", 64'(ack_b), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        acks = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (ack_b) acks++;
        end
        chk("wait_rst_stray", 64'(acks), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
